// File: rtl/rr_burst_mux_arbiter_pkg.sv
// rr_burst_mux_arbiter_pkg: shared FSM state type and requester sizing for the burst arbiter
package rr_burst_mux_arbiter_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/rr_burst_mux_arbiter_pick4.sv
// rr_pick4: combinational round-robin pick of the first request at or after i_ptr
// ports: i_req request vector, i_ptr scan start, o_idx winning index, o_any some request present
module rr_pick4
  import rr_burst_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);
  logic [NREQ-1:0]  w_rot;
  logic [SEL_W-1:0] w_off;
  for (genvar g = 0; g < NREQ; g++) begin : g_rot
    assign w_rot[g] = i_req[i_ptr + SEL_W'(g)];
  end
  assign w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign o_idx = i_ptr + w_off;
  assign o_any = |i_req;
endmodule

// File: rtl/rr_burst_mux_arbiter.sv
// rr_burst_mux_arbiter: round-robin burst arbiter driving a registered 4:1 data path with backpressure
// ports: i_data_k/i_valid/i_last/o_ready requester side, o_data/o_valid/o_sel/o_last/i_ready downstream side,
// o_busy high while a burst holds the grant, o_timeout one-cycle pulse on a forced release
module rr_burst_mux_arbiter
  import rr_burst_mux_arbiter_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data_0,
  input  logic [DATA_W-1:0] i_data_1,
  input  logic [DATA_W-1:0] i_data_2,
  input  logic [DATA_W-1:0] i_data_3,
  input  logic [NREQ-1:0]   i_valid,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_timeout
);
  localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_grant, w_grant_nxt, r_ptr, w_ptr_nxt, w_pick, r_sel;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_any, w_acc, w_gvalid, w_glast, w_expire, w_to_nxt;
  logic              r_timeout, r_valid, r_last;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_din [NREQ];
  assign w_din[0] = i_data_0;
  assign w_din[1] = i_data_1;
  assign w_din[2] = i_data_2;
  assign w_din[3] = i_data_3;
  rr_pick4 u_pick (
    .i_req (i_valid),
    .i_ptr (r_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );
  assign o_ready   = (r_state == LOCK && (!r_valid || i_ready)) ? NREQ'(1) << r_grant : '0;
  assign w_acc     = |(i_valid & o_ready);
  assign w_gvalid  = i_valid[r_grant];
  assign w_glast   = i_last[r_grant];
  // the edge that would bring the idle count up to TIMEOUT is the release edge
  assign w_expire  = TIMEOUT > 0 && r_state == LOCK && !w_gvalid && r_cnt == CNT_LAST;
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_sel     = r_sel;
  assign o_last    = r_last;
  assign o_busy    = r_state == LOCK;
  assign o_timeout = r_timeout;
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
    if (r_state == IDLE) begin
      w_state_nxt = w_any ? LOCK : IDLE;
      w_grant_nxt = w_any ? w_pick : r_grant;
    end else if ((w_acc && w_glast) || w_expire) begin
      w_state_nxt = IDLE;
      w_ptr_nxt   = r_grant + 1'b1;
      w_cnt_nxt   = '0;
      w_to_nxt    = w_expire;
    end else if (w_acc) begin
      w_cnt_nxt   = '0;
    end else if (!w_gvalid && TIMEOUT > 0) begin
      w_cnt_nxt   = r_cnt + 1'b1;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_to_nxt;
    end
  end
  // a new beat overwrites the register in the same cycle the old one leaves, so no bubble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_last  <= 1'b0;
    end else if (w_acc) begin
      r_data  <= w_din[r_grant];
      r_valid <= 1'b1;
      r_sel   <= r_grant;
      r_last  <= w_glast;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_burst_mux_arbiter.sv
// tb_rr_burst_mux_arbiter: directed stimulus with a scoreboard queue checked by a decoupled output monitor
module tb_rr_burst_mux_arbiter;
  logic        clk = 1'b0;
  logic        i_rst, i_ready;
  logic        v_a [4];
  logic        l_a [4];
  logic [15:0] d_a [4];
  logic [3:0]  i_valid, i_last, o_ready;
  logic [15:0] o_data;
  logic        o_valid, o_last, o_busy, o_timeout;
  logic [1:0]  o_sel;
  int          checks = 0;
  int          errors = 0;
  logic [18:0] sb [$];
  always #5 clk = ~clk;
  assign i_valid = {v_a[3], v_a[2], v_a[1], v_a[0]};
  assign i_last  = {l_a[3], l_a[2], l_a[1], l_a[0]};
  rr_burst_mux_arbiter #(.DATA_W(16), .TIMEOUT(4)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_data_0  (d_a[0]),
    .i_data_1  (d_a[1]),
    .i_data_2  (d_a[2]),
    .i_data_3  (d_a[3]),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_sel     (o_sel),
    .o_last    (o_last),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic push(input logic [1:0] s, input logic lst, input logic [15:0] d);
    sb.push_back({s, lst, d});
  endtask
  task automatic beat(input int k, input logic [15:0] dat, input logic lst);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    d_a[k] = dat;
    l_a[k] = lst;
    v_a[k] = 1'b1;
    while (!acc && !i_rst && n < 100) begin
      @(negedge clk);
      acc = o_ready[k];
      @(posedge clk);
      #1;
      n++;
    end
    v_a[k] = 1'b0;
    if (!acc && !i_rst) begin
      checks++;
      errors++;
      $display("FAIL beat_wait req %0d data %h never accepted", k, dat);
    end
  endtask
  task automatic burst(input int k, input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++) beat(k, base + 16'(i), i == len - 1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
  endtask
  task automatic reset_dut();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 50);
    if (!o_valid) chk("wait_valid_timeout", 0, 1);
  endtask
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = '0;
  logic [1:0]  ps = '0;
  logic [18:0] ex;
  always @(negedge clk) begin
    if (i_rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && o_valid) chk("hold_stable", {o_sel, o_data}, {ps, pd});
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", {o_sel, o_last, o_data}, 19'h7ffff);
        end else begin
          ex = sb.pop_front();
          chk("sb_beat", {o_sel, o_last, o_data}, ex);
        end
      end
      pv = o_valid;
      pr = i_ready;
      pd = o_data;
      ps = o_sel;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [14:0] pat;
    int n;
    i_rst = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_a[i] = 1'b0;
      l_a[i] = 1'b0;
      d_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_data, o_valid, o_sel, o_last, o_ready, o_busy, o_timeout}, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    push(2'd0, 1'b0, 16'hA000);
    push(2'd0, 1'b0, 16'hA001);
    push(2'd0, 1'b1, 16'hA002);
    fork
      burst(0, 16'hA000, 3);
      begin
        @(negedge clk);
        chk("t1_c0_ready", {o_busy, o_ready, o_valid}, 0);
        @(negedge clk);
        chk("t1_c1_ready", {o_busy, o_ready, o_valid}, {1'b1, 4'b0001, 1'b0});
        @(negedge clk);
        chk("t1_c2_valid", {o_valid, o_data}, {1'b1, 16'hA000});
        @(negedge clk);
        @(negedge clk);
        chk("t1_c4_last", {o_valid, o_last, o_busy, o_data}, {1'b1, 1'b1, 1'b0, 16'hA002});
      end
    join
    drain();
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push(2'(k), 1'b1, 16'hB000 + 16'(r * 16 + k));
    fork
      begin beat(0, 16'hB000, 1); beat(0, 16'hB010, 1); end
      begin beat(1, 16'hB001, 1); beat(1, 16'hB011, 1); end
      begin beat(2, 16'hB002, 1); beat(2, 16'hB012, 1); end
      begin beat(3, 16'hB003, 1); beat(3, 16'hB013, 1); end
      begin
        wait_valid();
        for (int i = 0; i < 15; i++) begin
          pat[14-i] = o_valid;
          @(negedge clk);
        end
        chk("t2_bubbles", pat, 15'h5555);
      end
    join
    drain();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd1, i == 3, 16'hC000 + 16'(i));
    fork
      burst(1, 16'hC000, 4);
      begin
        wait_valid();
        repeat (3) begin
          chk("t3_hold", {o_ready, o_data}, {4'b0000, 16'hC000});
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 4; i++) push(2'd2, i == 3, 16'hD000 + 16'(i));
    push(2'd0, 1'b1, 16'hE000);
    fork
      burst(2, 16'hD000, 4);
      begin
        repeat (2) @(posedge clk);
        #1;
        beat(0, 16'hE000, 1);
      end
    join
    drain();
    i_ready = 1'b0;
    push(2'd3, 1'b0, 16'hF000);
    push(2'd0, 1'b1, 16'h1000);
    push(2'd3, 1'b1, 16'h3000);
    beat(3, 16'hF000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_timeout && n < 20);
    chk("t5_timeout_cycles", n, 5);
    chk("t5_released", {o_busy, o_valid, o_data}, {1'b0, 1'b1, 16'hF000});
    @(negedge clk);
    chk("t5_pulse_once", o_timeout, 0);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    fork
      beat(3, 16'h3000, 1'b1);
      beat(0, 16'h1000, 1'b1);
    join
    drain();
    push(2'd1, 1'b1, 16'h5100);
    beat(1, 16'h5100, 1'b1);
    drain();
    i_ready = 1'b0;
    fork
      burst(2, 16'h6200, 4);
      begin
        wait_valid();
        #2;
        i_rst = 1'b1;
        #1;
        chk("t6_async_reset", {o_valid, o_ready, o_busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        i_ready = 1'b1;
      end
    join
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_resume", {o_valid, o_busy}, 0);
    end
    @(posedge clk);
    #1;
    push(2'd0, 1'b1, 16'h7000);
    push(2'd2, 1'b1, 16'h7200);
    fork
      beat(2, 16'h7200, 1'b1);
      beat(0, 16'h7000, 1'b1);
    join
    drain();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
